ram_port_arbiter: RTL and testbench

//  Shares the single synchronous data-RAM port between the CPU data side (behind the RAM cache) and a

---
 rtl/ram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one synchronous data-RAM port between the CPU data side (behind
//   the RAM cache) and a secondary DMA/debug-loader requester.
//   The CPU has fixed priority. A starvation counter forces one DMA grant
//   after MAX_CPU_BURST consecutive CPU grants while DMA is waiting.
//   Writes take one cycle. Reads take two: an address cycle, then a data cycle.
//
// Ports
//   clk, resetN                  clock; asynchronous active-low reset
//   cpu_read_m / cpu_write_m     CPU level requests, held while cpu_stall=1
//   cpu_data_addr, cpu_out_m     CPU address and write data
//   cpu_in_m                     CPU read data, valid in the CPU read data cycle
//   cpu_stall                    CPU must hold its request and freeze
//   dma_read / dma_write         DMA level requests, held until dma_ack
//   dma_addr, dma_wdata          DMA address and write data
//   dma_ack                      pulse: DMA request issued to RAM this cycle
//   dma_rdata, dma_rvalid        DMA read data and its one-cycle valid pulse
//   ram_in_m                     RAM read data, one cycle after the address
//   ram_out_m, ram_write_m,
//   ram_data_addr                RAM write data, write enable and address
module ram_port_arbiter #(
  parameter int DATA_WIDTH         = 16,
  parameter int RAM_REGISTER_COUNT = 1024,
  parameter int MAX_CPU_BURST      = 4,
  localparam int AW = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  cpu_read_m,
  input  logic                  cpu_write_m,
  input  logic [AW-1:0]         cpu_data_addr,
  input  logic [DATA_WIDTH-1:0] cpu_out_m,
  output logic [DATA_WIDTH-1:0] cpu_in_m,
  output logic                  cpu_stall,
  input  logic                  dma_read,
  input  logic                  dma_write,
  input  logic [AW-1:0]         dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_rvalid,
  input  logic [DATA_WIDTH-1:0] ram_in_m,
  output logic [DATA_WIDTH-1:0] ram_out_m,
  output logic                  ram_write_m,
  output logic [AW-1:0]         ram_data_addr
);

  localparam int CW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_CPU_BURST);

  typedef enum logic [1:0] {
    IDLE,
    CPU_RD,
    DMA_RD
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] starve_cnt;
  logic          cpu_req;
  logic          dma_req;
  logic          dma_priority;
  logic          cpu_grant;
  logic          dma_grant;

  assign cpu_req = cpu_read_m | cpu_write_m;
  assign dma_req = dma_read | dma_write;

  // DMA wins when it is alone, or when the CPU has used up its burst
  // allowance while DMA was waiting.
  assign dma_priority = dma_req && (!cpu_req || (starve_cnt == BURST_LIMIT));
  assign cpu_grant    = (state == IDLE) && cpu_req && !dma_priority;
  assign dma_grant    = (state == IDLE) && dma_priority;

  // Read data passes straight through from the RAM. It is only meaningful
  // in the matching read data cycle.
  assign cpu_in_m  = ram_in_m;
  assign dma_rdata = ram_in_m;

  // State register. An asynchronous reset drops any read that is in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Only a read grant leaves IDLE. When read and write
  // are both asserted, the write wins, so the read data cycle is skipped.
  always_comb begin
    next_state = IDLE;
    unique case (state)
      IDLE: begin
        if (cpu_grant && !cpu_write_m) begin
          next_state = CPU_RD;
        end else if (dma_grant && !dma_write) begin
          next_state = DMA_RD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Starvation counter. It counts CPU grants taken while DMA waits and
  // saturates at the limit. It clears when DMA is served or goes idle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_cnt <= '0;
    end else if (!dma_req || dma_grant) begin
      starve_cnt <= '0;
    end else if (cpu_grant && (starve_cnt != BURST_LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Output logic. A pending CPU request stalls by default. Only a CPU
  // write grant or the CPU read data cycle releases it. Reset forces a
  // stall and a quiet RAM port.
  always_comb begin
    ram_write_m   = 1'b0;
    ram_data_addr = '0;
    ram_out_m     = '0;
    dma_ack       = 1'b0;
    dma_rvalid    = 1'b0;
    cpu_stall     = cpu_req;
    if (!resetN) begin
      cpu_stall = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_grant) begin
            ram_data_addr = cpu_data_addr;
            if (cpu_write_m) begin
              ram_write_m = 1'b1;
              ram_out_m   = cpu_out_m;
              cpu_stall   = 1'b0;
            end
          end else if (dma_grant) begin
            ram_data_addr = dma_addr;
            dma_ack       = 1'b1;
            if (dma_write) begin
              ram_write_m = 1'b1;
              ram_out_m   = dma_wdata;
            end
          end
        end
        CPU_RD: cpu_stall = 1'b0;
        DMA_RD: dma_rvalid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter. A behavioural synchronous RAM
//   sits on the RAM port. Expected read data goes into a scoreboard queue
//   when a read is requested. It is popped and compared in the data cycle.
module tb_ram_port_arbiter;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          cpu_read_m, cpu_write_m;
  logic [AW-1:0] cpu_data_addr;
  logic [DW-1:0] cpu_out_m, cpu_in_m;
  logic          cpu_stall;
  logic          dma_read, dma_write;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] ram_in_m, ram_out_m;
  logic          ram_write_m;
  logic [AW-1:0] ram_data_addr;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_data;
  int            vectors = 0;
  int            miscompares = 0;

  ram_port_arbiter #(
    .DATA_WIDTH(DW),
    .RAM_REGISTER_COUNT(DEPTH),
    .MAX_CPU_BURST(BURST)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .cpu_read_m(cpu_read_m),
    .cpu_write_m(cpu_write_m),
    .cpu_data_addr(cpu_data_addr),
    .cpu_out_m(cpu_out_m),
    .cpu_in_m(cpu_in_m),
    .cpu_stall(cpu_stall),
    .dma_read(dma_read),
    .dma_write(dma_write),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_ack(dma_ack),
    .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .ram_in_m(ram_in_m),
    .ram_out_m(ram_out_m),
    .ram_write_m(ram_write_m),
    .ram_data_addr(ram_data_addr)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: write on the edge, read data one cycle later.
  always @(posedge clk) begin
    if (ram_write_m) ram_mem[ram_data_addr] <= ram_out_m;
    ram_in_m <= ram_mem[ram_data_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_read_m = 1'b0; cpu_write_m = 1'b0; cpu_data_addr = '0; cpu_out_m = '0;
    dma_read = 1'b0; dma_write = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetN = 1'b0;
    cpu_write_m = 1'b1; cpu_data_addr = AW'(9); cpu_out_m = 16'h5555;
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_stall got=%b exp=1", cpu_stall); end
    vectors++; if (ram_write_m !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we got=%b exp=0", ram_write_m); end
    vectors++; if (ram_data_addr !== '0) begin miscompares++; $display("[TB] FAIL rst_addr got=%0h exp=0", ram_data_addr); end
    vectors++; if (ram_out_m !== '0) begin miscompares++; $display("[TB] FAIL rst_wdata got=%0h exp=0", ram_out_m); end
    vectors++; if (dma_ack !== 1'b0 || dma_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dma got=%b%b exp=00", dma_ack, dma_rvalid); end
    next_cycle();
    clear_inputs();
    resetN = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_write();
    cpu_write_m = 1'b1; cpu_data_addr = AW'(5); cpu_out_m = 16'h1234;
    @(negedge clk);
    vectors++; if (ram_write_m !== 1'b1) begin miscompares++; $display("[TB] FAIL cpu_wr_we got=%b exp=1", ram_write_m); end
    vectors++; if (ram_data_addr !== AW'(5)) begin miscompares++; $display("[TB] FAIL cpu_wr_addr got=%0h exp=5", ram_data_addr); end
    vectors++; if (ram_out_m !== 16'h1234) begin miscompares++; $display("[TB] FAIL cpu_wr_data got=%0h exp=1234", ram_out_m); end
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_wr_stall got=%b exp=0", cpu_stall); end
    model_mem[5] = 16'h1234;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_cpu_read(input int addr, input string tag);
    cpu_read_m = 1'b1; cpu_data_addr = AW'(addr);
    exp_q.push_back(model_mem[addr]);
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_grant_stall got=%b exp=1", tag, cpu_stall); end
    vectors++; if (ram_data_addr !== AW'(addr) || ram_write_m !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_grant_addr got=%0h/%b exp=%0h/0", tag, ram_data_addr, ram_write_m, addr); end
    next_cycle();
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_data_stall got=%b exp=0", tag, cpu_stall); end
    vectors++;
    if (exp_q.size() == 0) begin miscompares++; $display("[TB] FAIL %s_data scoreboard empty", tag); end
    else begin
      exp_data = exp_q.pop_front();
      if (cpu_in_m !== exp_data) begin miscompares++; $display("[TB] FAIL %s_data got=%0h exp=%0h", tag, cpu_in_m, exp_data); end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_dma();
    bit got;
    dma_write = 1'b1; dma_addr = AW'(7); dma_wdata = 16'hBEEF;
    @(negedge clk);
    vectors++; if (dma_ack !== 1'b1 || ram_write_m !== 1'b1) begin miscompares++; $display("[TB] FAIL dma_wr_ack_we got=%b%b exp=11", dma_ack, ram_write_m); end
    vectors++; if (ram_data_addr !== AW'(7) || ram_out_m !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL dma_wr_port got=%0h/%0h exp=7/beef", ram_data_addr, ram_out_m); end
    model_mem[7] = 16'hBEEF;
    next_cycle();
    clear_inputs();
    dma_read = 1'b1; dma_addr = AW'(7);
    exp_q.push_back(model_mem[7]);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (dma_ack === 1'b1) got = 1'b1;
      else next_cycle();
    end
    vectors++; if (!got) begin miscompares++; $display("[TB] FAIL dma_rd_ack timeout got=0 exp=1"); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++; if (dma_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL dma_rvalid got=%b exp=1", dma_rvalid); end
    vectors++;
    if (exp_q.size() == 0) begin miscompares++; $display("[TB] FAIL dma_rdata scoreboard empty"); end
    else begin
      exp_data = exp_q.pop_front();
      if (dma_rdata !== exp_data) begin miscompares++; $display("[TB] FAIL dma_rdata got=%0h exp=%0h", dma_rdata, exp_data); end
    end
    next_cycle();
    @(negedge clk);
    vectors++; if (dma_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL dma_rvalid_pulse got=%b exp=0", dma_rvalid); end
    next_cycle();
  endtask

  task automatic test_starvation();
    int idx;
    bit dma_turn;
    bit dma_done;
    dma_done = 1'b0;
    for (int c = 0; c <= BURST + 1; c++) begin
      idx = (c <= BURST) ? c : c - 1;
      dma_turn = (c == BURST);
      cpu_write_m = 1'b1; cpu_data_addr = AW'(16 + idx); cpu_out_m = 16'hA000 + DW'(idx);
      dma_write = !dma_done; dma_addr = AW'(32); dma_wdata = 16'h5A5A;
      @(negedge clk);
      vectors++; if (dma_ack !== dma_turn) begin miscompares++; $display("[TB] FAIL starve_ack c=%0d got=%b exp=%b", c, dma_ack, dma_turn); end
      vectors++; if (cpu_stall !== dma_turn) begin miscompares++; $display("[TB] FAIL starve_stall c=%0d got=%b exp=%b", c, cpu_stall, dma_turn); end
      vectors++; if (ram_data_addr !== (dma_turn ? AW'(32) : AW'(16 + idx))) begin miscompares++; $display("[TB] FAIL starve_addr c=%0d got=%0h", c, ram_data_addr); end
      if (dma_turn) dma_done = 1'b1;
      next_cycle();
    end
    clear_inputs();
    for (int k = 0; k <= BURST; k++) model_mem[16 + k] = 16'hA000 + DW'(k);
    model_mem[32] = 16'h5A5A;
    test_cpu_read(32, "starve_rd");
  endtask

  task automatic test_collision();
    dma_read = 1'b1; dma_addr = AW'(7);
    exp_q.push_back(model_mem[7]);
    @(negedge clk);
    vectors++; if (dma_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_ack got=%b exp=1", dma_ack); end
    next_cycle();
    clear_inputs();
    cpu_read_m = 1'b1; cpu_data_addr = AW'(17);
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_stall got=%b exp=1", cpu_stall); end
    vectors++; if (ram_data_addr !== '0 || ram_write_m !== 1'b0) begin miscompares++; $display("[TB] FAIL coll_no_op got=%0h/%b exp=0/0", ram_data_addr, ram_write_m); end
    vectors++;
    if (exp_q.size() == 0 || dma_rvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL coll_dma_data rvalid=%b exp=1", dma_rvalid); end
    else begin
      exp_data = exp_q.pop_front();
      if (dma_rdata !== exp_data) begin miscompares++; $display("[TB] FAIL coll_dma_data got=%0h exp=%0h", dma_rdata, exp_data); end
    end
    next_cycle();
    test_cpu_read(17, "coll_cpu");
  endtask

  task automatic test_read_write_both();
    cpu_read_m = 1'b1; cpu_write_m = 1'b1; cpu_data_addr = AW'(48); cpu_out_m = 16'h7777;
    @(negedge clk);
    vectors++; if (ram_write_m !== 1'b1 || cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_both got=%b/%b exp=1/0", ram_write_m, cpu_stall); end
    next_cycle();
    clear_inputs();
    dma_write = 1'b1; dma_addr = AW'(49); dma_wdata = 16'h0F0F;
    @(negedge clk);
    vectors++; if (dma_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL rw_read_dropped got=%b exp=1", dma_ack); end
    next_cycle();
    clear_inputs();
    model_mem[48] = 16'h7777;
    test_cpu_read(48, "rw_rd");
  endtask

  task automatic test_reset_mid_read();
    cpu_read_m = 1'b1; cpu_data_addr = AW'(5);
    next_cycle();
    resetN = 1'b0;
    @(negedge clk);
    vectors++; if (cpu_stall !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_stall got=%b exp=1", cpu_stall); end
    vectors++; if (ram_write_m !== 1'b0 || ram_data_addr !== '0 || ram_out_m !== '0) begin miscompares++; $display("[TB] FAIL midrst_port got=%b/%0h/%0h exp=0/0/0", ram_write_m, ram_data_addr, ram_out_m); end
    vectors++; if (dma_ack !== 1'b0 || dma_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_dma got=%b%b exp=00", dma_ack, dma_rvalid); end
    next_cycle();
    resetN = 1'b1;
    test_cpu_read(5, "postrst_rd");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    ram_in_m = '0;
    test_reset();
    test_cpu_write();
    test_cpu_read(5, "cpu_rd");
    test_dma();
    test_starvation();
    test_collision();
    test_read_write_both();
    test_reset_mid_read();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
